// File: rtl/uart_rx_fifo.sv
// Receive-side elastic buffer: a storage array in front of a registered
// first-word-fall-through output stage. Bytes offered while full are dropped and counted.
module uart_rx_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic [7:0]            drop_count,
    input  logic                  clear_overflow
);

    localparam int                    DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CAPACITY = (DEPTH_LOG2 + 1)'(DEPTH + 1);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [DEPTH_LOG2:0]   arr_count;
    logic                  out_valid_q, out_valid_d;
    logic [WIDTH-1:0]      out_data_q;
    logic                  overflow_q, overflow_d;
    logic [7:0]            drop_count_q, drop_count_d;

    logic push, pop, drop;
    logic arr_nonempty, refill, arr_read, bypass, arr_write;

    // in_ready looks only at registered level, never at out_ready.
    assign in_ready     = (level_q != CAPACITY);
    assign push         = in_valid & in_ready;
    assign pop          = out_valid_q & out_ready;
    assign drop         = in_valid & ~in_ready;

    assign arr_count    = level_q - {{DEPTH_LOG2{1'b0}}, out_valid_q};
    assign arr_nonempty = (arr_count != '0);
    assign refill       = ~out_valid_q | out_ready;
    assign arr_read     = refill & arr_nonempty;
    assign bypass       = refill & ~arr_nonempty & push;
    assign arr_write    = push & ~bypass;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        out_valid_d  = out_valid_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;

        if (refill) begin
            out_valid_d = arr_nonempty | push;
        end
        if (arr_read) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (arr_write) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        // A clear in the same cycle as a drop wins; that drop goes uncounted.
        if (clear_overflow) begin
            overflow_d   = 1'b0;
            drop_count_d = 8'd0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != 8'hFF) begin
                drop_count_d = drop_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            out_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            out_valid_q  <= out_valid_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Output register doubles as the array's registered read port.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_data_q <= '0;
        end else if (arr_read) begin
            out_data_q <= mem_q[rd_ptr_q];
        end else if (bypass) begin
            out_data_q <= in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (arr_write) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and scoreboard-checked stimulus for uart_rx_fifo (WIDTH=8, DEPTH_LOG2=4).
module tb_uart_rx_fifo;

    localparam int CAP = 17;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [4:0] level;
    logic       overflow;
    logic [7:0] drop_count;
    logic       clear_overflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_q[$];
    int         m_drops = 0;
    bit         m_ovf   = 1'b0;

    uart_rx_fifo #(.WIDTH(8), .DEPTH_LOG2(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .level          (level),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .clear_overflow (clear_overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    // One clock of stimulus checked against a queue model of the buffer.
    task automatic m_cycle(input bit iv, input logic [7:0] d, input bit ordy,
                           input bit clr, input bit rst);
        bit exp_ready, p, po, dr;
        logic [7:0] popped;
        exp_ready = (model_q.size() != CAP);
        if (!rst) check("m_in_ready", 32'(in_ready), 32'(exp_ready));
        in_valid = iv; in_data = d; out_ready = ordy; clear_overflow = clr; reset = rst;
        p  = iv && exp_ready;
        po = ordy && (model_q.size() > 0);
        dr = iv && !exp_ready;
        popped = (model_q.size() > 0) ? model_q[0] : 8'h00;
        step;
        in_valid = 1'b0; clear_overflow = 1'b0; reset = 1'b0;
        if (rst) begin
            model_q.delete();
            m_drops = 0;
            m_ovf   = 1'b0;
        end else begin
            if (po) begin
                void'(model_q.pop_front());
                $display("[%0t] pop 0x%02h", $time, popped);
            end
            if (p) model_q.push_back(d);
            if (clr) begin
                m_ovf = 1'b0; m_drops = 0;
            end else if (dr) begin
                m_ovf = 1'b1;
                if (m_drops < 255) m_drops++;
            end
        end
        check("m_level", 32'(level), 32'(model_q.size()));
        check("m_out_valid", 32'(out_valid), 32'(model_q.size() > 0));
        if (model_q.size() > 0) check("m_out_data", 32'(out_data), 32'(model_q[0]));
        check("m_overflow", 32'(overflow), 32'(m_ovf));
        check("m_drop_count", 32'(drop_count), 32'(m_drops));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; clear_overflow = 1'b0;
        step; step;
        reset = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        step;
        check("post_rst_out_valid", 32'(out_valid), 32'd0);

        // Single byte: one-cycle latency, stable under backpressure, then pop.
        in_valid = 1'b1; in_data = 8'h41;
        step;
        in_valid = 1'b0;
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_out_data", 32'(out_data), 32'h41);
        check("t1_level", 32'(level), 32'd1);
        repeat (10) begin
            step;
            check("t1_stable", 32'(out_data), 32'h41);
        end
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        $display("[%0t] pop 0x41", $time);
        check("t1_level_after_pop", 32'(level), 32'd0);
        check("t1_valid_after_pop", 32'(out_valid), 32'd0);

        // Fill past capacity: 17 accepted, 0x11 dropped, then drain in order.
        for (int i = 0; i < 18; i++) begin
            check("t2_in_ready", 32'(in_ready), 32'(i < 17));
            in_valid = 1'b1; in_data = 8'(i);
            step;
        end
        in_valid = 1'b0;
        check("t2_level", 32'(level), 32'd17);
        check("t2_in_ready_full", 32'(in_ready), 32'd0);
        check("t2_overflow", 32'(overflow), 32'd1);
        check("t2_drop_count", 32'(drop_count), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            check("t2_drain_valid", 32'(out_valid), 32'd1);
            check("t2_drain_data", 32'(out_data), 32'(i));
            $display("[%0t] pop 0x%02h", $time, out_data);
            step;
        end
        out_ready = 1'b0;
        check("t2_empty_valid", 32'(out_valid), 32'd0);
        check("t2_empty_level", 32'(level), 32'd0);

        // Full with push and pop together: pop happens, push is dropped.
        clear_overflow = 1'b1;
        step;
        clear_overflow = 1'b0;
        check("t3_clr_overflow", 32'(overflow), 32'd0);
        check("t3_clr_drops", 32'(drop_count), 32'd0);
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h20 + i);
            step;
        end
        check("t3_full_level", 32'(level), 32'd17);
        in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
        step;
        in_valid = 1'b0; out_ready = 1'b0;
        check("t3_level", 32'(level), 32'd16);
        check("t3_drop_count", 32'(drop_count), 32'd1);
        check("t3_overflow", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        for (int i = 1; i < 17; i++) begin
            check("t3_drain_data", 32'(out_data), 32'(8'h20 + i));
            $display("[%0t] pop 0x%02h", $time, out_data);
            step;
        end
        out_ready = 1'b0;
        check("t3_empty_valid", 32'(out_valid), 32'd0);

        // Streaming at level 1, then streaming with a backlog to wrap the pointers.
        m_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        m_cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 100; i++) begin
            m_cycle(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
            check("t4_level_one", 32'(level), 32'd1);
        end
        m_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) m_cycle(1'b1, 8'(100 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) m_cycle(1'b1, 8'(103 + i), 1'b1, 1'b0, 1'b0);
        repeat (5) m_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Random traffic with a mid-stream reset.
        for (int c = 0; c < 1000; c++) begin
            bit iv, ordy, clr;
            iv   = ($urandom_range(0, 9) < ((c < 300) ? 8 : 5));
            ordy = ($urandom_range(0, 9) < ((c < 300) ? 2 : 5));
            clr  = ($urandom_range(0, 99) == 0);
            m_cycle(iv, 8'($urandom), ordy, clr, (c == 600));
        end

        // Saturating drop counter and clear-beats-drop.
        reset = 1'b1;
        step;
        reset = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            step;
        end
        in_valid = 1'b1;
        repeat (255) step;
        check("t6_drops_255", 32'(drop_count), 32'd255);
        repeat (45) step;
        check("t6_drops_sat", 32'(drop_count), 32'd255);
        check("t6_overflow", 32'(overflow), 32'd1);
        clear_overflow = 1'b1;
        step;
        clear_overflow = 1'b0;
        check("t6_clr_overflow", 32'(overflow), 32'd0);
        check("t6_clr_drops", 32'(drop_count), 32'd0);
        step;
        in_valid = 1'b0;
        check("t6_drop_after_clr", 32'(drop_count), 32'd1);
        check("t6_level_full", 32'(level), 32'd17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
